// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite scan/render sequencer.
package sprite_pkg;

    localparam int NUM_SLOTS    = 10;
    localparam int NUM_OAM      = 40;
    localparam int LINE_W       = 4;
    localparam int OBJ_Y_OFFSET = 16;
    localparam int OBJ_H_SHORT  = 8;
    localparam int OBJ_H_TALL   = 16;

    typedef struct packed {
        logic              valid;
        logic [5:0]        idx;
        logic [LINE_W-1:0] line;
        logic [7:0]        x;
    } slot_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCAN_A = 3'd1,
        SCAN_B = 3'd2,
        RENDER = 3'd3,
        FETCH  = 3'd4
    } state_t;

    // OAM Y is stored offset by 16, so the row inside the sprite is ly + 16 - y (mod 512).
    function automatic logic [8:0] y_diff(input logic [7:0] ly, input logic [7:0] y);
        return {1'b0, ly} + 9'(OBJ_Y_OFFSET) - {1'b0, y};
    endfunction

endpackage

// File: rtl/sprite_slot_match.sv
// Compares every valid slot X against the pixel counter; lowest slot number wins.
module sprite_slot_match
    import sprite_pkg::*;
(
    input  slot_t [NUM_SLOTS-1:0] slots,
    input  logic                  enable,
    input  logic [7:0]            pix_x,
    output logic                  hit,
    output logic [3:0]            hit_slot
);

    always_comb begin
        hit      = 1'b0;
        hit_slot = '0;
        // Walk downward so the last assignment is the lowest matching slot.
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (enable && slots[i].valid && (slots[i].x == pix_x)) begin
                hit      = 1'b1;
                hit_slot = 4'(i);
            end
        end
    end

endmodule

// File: rtl/sprite_scan_ctrl.sv
// OAM scan allocates up to 10 sprites for the line; rendering fetches them as X matches.
module sprite_scan_ctrl
    import sprite_pkg::*;
(
    input  logic       clk,
    input  logic       nreset,
    input  logic       scan_start,
    input  logic [7:0] ly,
    input  logic       obj_tall,
    output logic [5:0] oam_idx,
    input  logic [7:0] oam_y,
    input  logic [7:0] oam_x,
    output logic       scanning,
    output logic       scan_done,
    output logic [3:0] slot_count,
    input  logic       render_en,
    input  logic [7:0] pix_x,
    output logic       stall,
    output logic       fetch_req,
    output logic [5:0] fetch_idx,
    output logic [3:0] fetch_line,
    input  logic       fetch_ack,
    output logic [2:0] dbg_state
);

    state_t                state_q, state_d;
    logic [5:0]            idx_q, idx_d;
    slot_t [NUM_SLOTS-1:0] slots_q, slots_d;
    logic [3:0]            slot_count_q, slot_count_d;
    logic                  scan_done_q, scan_done_d;
    logic                  fetch_req_q, fetch_req_d;
    logic [5:0]            fetch_idx_q, fetch_idx_d;
    logic [3:0]            fetch_line_q, fetch_line_d;
    logic [3:0]            fetch_slot_q, fetch_slot_d;

    logic                  match_hit;
    logic [3:0]            match_slot;
    logic [8:0]            diff;
    logic                  y_hit;

    sprite_slot_match u_match (
        .slots    (slots_q),
        .enable   (render_en && (state_q == RENDER)),
        .pix_x    (pix_x),
        .hit      (match_hit),
        .hit_slot (match_slot)
    );

    assign diff  = y_diff(ly, oam_y);
    assign y_hit = diff < (obj_tall ? 9'(OBJ_H_TALL) : 9'(OBJ_H_SHORT));

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        slots_d      = slots_q;
        slot_count_d = slot_count_q;
        scan_done_d  = 1'b0;
        fetch_req_d  = fetch_req_q;
        fetch_idx_d  = fetch_idx_q;
        fetch_line_d = fetch_line_q;
        fetch_slot_d = fetch_slot_q;

        if (scan_start) begin
            state_d      = SCAN_A;
            idx_d        = '0;
            slot_count_d = '0;
            fetch_req_d  = 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots_d[i].valid = 1'b0;
            end
        end else begin
            case (state_q)
                SCAN_A: state_d = SCAN_B;
                SCAN_B: begin
                    // Entries past a full store are still walked so scan length never varies.
                    if (y_hit && (slot_count_q < 4'(NUM_SLOTS))) begin
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            if (4'(i) == slot_count_q) begin
                                slots_d[i].valid = 1'b1;
                                slots_d[i].idx   = idx_q;
                                slots_d[i].line  = diff[3:0];
                                slots_d[i].x     = oam_x;
                            end
                        end
                        slot_count_d = slot_count_q + 4'd1;
                    end
                    if (idx_q == 6'(NUM_OAM - 1)) begin
                        state_d     = RENDER;
                        scan_done_d = 1'b1;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        state_d = SCAN_A;
                    end
                end
                RENDER: begin
                    if (match_hit) begin
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            if (4'(i) == match_slot) begin
                                fetch_idx_d  = slots_q[i].idx;
                                fetch_line_d = slots_q[i].line;
                            end
                        end
                        fetch_slot_d = match_slot;
                        fetch_req_d  = 1'b1;
                        state_d      = FETCH;
                    end
                end
                FETCH: begin
                    if (fetch_ack) begin
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            if (4'(i) == fetch_slot_q) begin
                                slots_d[i].valid = 1'b0;
                            end
                        end
                        fetch_req_d = 1'b0;
                        state_d     = RENDER;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            slots_q      <= '0;
            slot_count_q <= '0;
            scan_done_q  <= 1'b0;
            fetch_req_q  <= 1'b0;
            fetch_idx_q  <= '0;
            fetch_line_q <= '0;
            fetch_slot_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            slots_q      <= slots_d;
            slot_count_q <= slot_count_d;
            scan_done_q  <= scan_done_d;
            fetch_req_q  <= fetch_req_d;
            fetch_idx_q  <= fetch_idx_d;
            fetch_line_q <= fetch_line_d;
            fetch_slot_q <= fetch_slot_d;
        end
    end

    assign oam_idx    = idx_q;
    assign scanning   = (state_q == SCAN_A) || (state_q == SCAN_B);
    assign scan_done  = scan_done_q;
    assign slot_count = slot_count_q;
    assign fetch_req  = fetch_req_q;
    assign fetch_idx  = fetch_idx_q;
    assign fetch_line = fetch_line_q;
    // Holds the pixel counter from the match cycle until the fetch is acknowledged.
    assign stall      = fetch_req_q | match_hit;
    assign dbg_state  = state_q;

endmodule
